// File: rtl/sram_sp_be_init_if.sv
// sram_sp_be_init_if: access bus of the single-port byte-enabled SRAM.
// Control pins are active low; Q/BUSY/ERR flow back from the memory.
interface sram_sp_be_init_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                    CEN;
  logic                    GWEN;
  logic [DATA_WIDTH/8-1:0] BEN;
  logic [ADDR_WIDTH-1:0]   A;
  logic [DATA_WIDTH-1:0]   D;
  logic [DATA_WIDTH-1:0]   Q;
  logic                    BUSY;
  logic                    ERR;

  modport master (
    output CEN, GWEN, BEN, A, D,
    input  Q, BUSY, ERR
  );

  modport slave (
    input  CEN, GWEN, BEN, A, D,
    output Q, BUSY, ERR
  );
endinterface

// File: rtl/sram_sp_be_init.sv
// sram_sp_be_init: single-port byte-enabled SRAM that fills itself with
// INIT_VALUE after every reset and flags out-of-range accesses.
module sram_sp_be_init #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic              CLK,
  input logic              RST,
  sram_sp_be_init_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LIM =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                state, nstate;
  logic [ADDR_WIDTH-1:0] cnt, ncnt;
  logic [DATA_WIDTH-1:0] q0, q1;
  logic                  err;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic acc, inr, wr_en, rd_en;

  assign acc   = (state == READY) && !bus.CEN;
  assign inr   = {1'b0, bus.A} < LIM;
  assign wr_en = acc && !bus.GWEN && inr;
  assign rd_en = acc && bus.GWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    unique case (state)
      INIT: begin
        ncnt = cnt + 1'b1;
        if (cnt == LAST) begin
          nstate = READY;
          ncnt   = '0;
        end
      end
      READY: begin
        nstate = READY;
      end
      default: nstate = INIT;
    endcase
  end

  // The array itself is never reset; the init sweep rewrites it.
  always_ff @(posedge CLK) begin
    if (state == INIT) begin
      mem[cnt] <= INIT_VALUE;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (!bus.BEN[i])
          mem[bus.A][8*i +: 8] <= bus.D[8*i +: 8];
      end
    end
  end

  // q1 follows q0 every cycle; q0 only moves on reads, so idles are safe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q0  <= '0;
      q1  <= '0;
      err <= 1'b0;
    end else begin
      if (rd_en)
        q0 <= inr ? mem[bus.A] : '0;
      q1  <= q0;
      err <= acc && !inr;
    end
  end

  assign bus.Q    = (OUT_REG != 0) ? q1 : q0;
  assign bus.BUSY = (state == INIT);
  assign bus.ERR  = err;
endmodule

// File: tb/tb_sram_sp_be_init.sv
// tb_sram_sp_be_init: directed checks of init, byte writes, latency,
// out-of-range handling and reset behaviour (OUT_REG=0 and OUT_REG=1).
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp); \
    end \
  end

module tb_sram_sp_be_init;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DP = 12;
  localparam logic [31:0] IV = 32'hA5A5_A5A5;

  logic       clk;
  logic       rst;
  logic       cen;
  logic       gwen;
  logic [3:0] ben;
  logic [3:0] a;
  logic [31:0] d;

  int total = 0;
  int bad   = 0;
  int n;
  int errs;

  sram_sp_be_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i0 ();
  sram_sp_be_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i1 ();

  assign i0.CEN  = cen;
  assign i0.GWEN = gwen;
  assign i0.BEN  = ben;
  assign i0.A    = a;
  assign i0.D    = d;
  assign i1.CEN  = cen;
  assign i1.GWEN = gwen;
  assign i1.BEN  = ben;
  assign i1.A    = a;
  assign i1.D    = d;

  sram_sp_be_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP),
    .OUT_REG(0), .INIT_VALUE(IV)
  ) dut0 (
    .CLK(clk), .RST(rst), .bus(i0)
  );

  sram_sp_be_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP),
    .OUT_REG(1), .INIT_VALUE(IV)
  ) dut1 (
    .CLK(clk), .RST(rst), .bus(i1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst  = 1'b1;
    cen  = 1'b1;
    gwen = 1'b1;
    ben  = 4'hF;
    a    = '0;
    d    = '0;
    @(negedge clk);
    @(negedge clk);
    `CHK("rst_busy", i0.BUSY, 1'b1)
    `CHK("rst_q", i0.Q, 32'h0)
    `CHK("rst_err", i0.ERR, 1'b0)

    // init length
    rst = 1'b0;
    n = 0;
    while (i0.BUSY && n < 40) begin
      @(negedge clk);
      n++;
    end
    `CHK("init_len", n, 12)

    for (int i = 0; i < DP; i++) begin
      cen = 1'b0; gwen = 1'b1; a = 4'(i);
      @(negedge clk);
      `CHK("rd_init", i0.Q, IV)
    end

    // byte-enabled write
    cen = 1'b0; gwen = 1'b0; a = 4'd3;
    d = 32'h1122_3344; ben = 4'b1010;
    @(negedge clk);
    `CHK("wr_q_hold", i0.Q, IV)
    gwen = 1'b1;
    @(negedge clk);
    `CHK("rd_be", i0.Q, 32'hA522_A544)
    cen = 1'b1; a = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      `CHK("idle_hold", i0.Q, 32'hA522_A544)
    end

    // back-to-back, both latencies
    ben = 4'h0;
    for (int i = 0; i < 4; i++) begin
      cen = 1'b0; gwen = 1'b0; a = 4'(i);
      d = 32'h0101_0101 * i;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      cen = 1'b0; gwen = 1'b1; a = 4'(i);
      @(negedge clk);
      `CHK("b2b_q0", i0.Q, 32'h0101_0101 * i)
      if (i == 0) begin
        `CHK("b2b_q1_lat", i1.Q, 32'hA522_A544)
      end else begin
        `CHK("b2b_q1", i1.Q, 32'h0101_0101 * (i - 1))
      end
    end
    cen = 1'b1;
    @(negedge clk);
    `CHK("b2b_q1_last", i1.Q, 32'h0303_0303)

    // out of range
    cen = 1'b0; gwen = 1'b0; a = 4'd13;
    d = 32'hFFFF_FFFF; ben = 4'h0;
    @(negedge clk);
    `CHK("oor_wr_err0", i0.ERR, 1'b1)
    `CHK("oor_wr_err1", i1.ERR, 1'b1)
    `CHK("oor_wr_q", i0.Q, 32'h0303_0303)
    cen = 1'b1;
    @(negedge clk);
    `CHK("oor_err_pulse", i0.ERR, 1'b0)
    cen = 1'b0; gwen = 1'b1; a = 4'd1;
    @(negedge clk);
    `CHK("oor_alias1", i0.Q, 32'h0101_0101)
    a = 4'd5;
    @(negedge clk);
    `CHK("oor_alias5", i0.Q, IV)
    a = 4'd15;
    @(negedge clk);
    `CHK("oor_rd_q", i0.Q, 32'h0)
    `CHK("oor_rd_err", i0.ERR, 1'b1)
    cen = 1'b1;
    @(negedge clk);
    `CHK("oor_rd_err_end", i0.ERR, 1'b0)
    `CHK("oor_rd_q1", i1.Q, 32'h0)

    // write, then reset (async) mid-READY
    cen = 1'b0; gwen = 1'b0; a = 4'd7;
    d = 32'hDEAD_BEEF; ben = 4'h0;
    @(negedge clk);
    gwen = 1'b1;
    @(negedge clk);
    `CHK("rd_beef", i0.Q, 32'hDEAD_BEEF)
    cen = 1'b1;
    #1 rst = 1'b1;
    #1;
    `CHK("arst_q0", i0.Q, 32'h0)
    `CHK("arst_busy", i0.BUSY, 1'b1)
    @(negedge clk);
    `CHK("arst_q1", i1.Q, 32'h0)
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    `CHK("midinit_busy", i0.BUSY, 1'b1)

    // reset at init cycle 5, accesses while busy
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    errs = 0;
    while (i0.BUSY && n < 40) begin
      cen = 1'b0; gwen = n[0]; ben = 4'h0; d = 32'h0;
      a = n[1] ? 4'd14 : 4'd2;
      @(negedge clk);
      n++;
      if (i0.ERR) errs++;
    end
    cen = 1'b1;
    `CHK("reinit_len", n, 12)
    `CHK("busy_err", errs, 0)
    `CHK("busy_q", i0.Q, 32'h0)

    cen = 1'b0; gwen = 1'b1; a = 4'd2;
    @(negedge clk);
    `CHK("busy_nowr", i0.Q, IV)
    a = 4'd7;
    @(negedge clk);
    `CHK("reinit_a7", i0.Q, IV)
    a = 4'd3;
    @(negedge clk);
    `CHK("reinit_a3", i0.Q, IV)
    `CHK("reinit_q1", i1.Q, IV)
    cen = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
